// File: rtl/blur_filter_param_if.sv
// Streaming pixel bus for blur_filter_param.
// Sink side:   valid_in, ready_in, startofpacket_in, endofpacket_in, data_in, blur_en
// Source side: valid_out, ready_out, startofpacket_out, endofpacket_out, data_out
// Status:      frame_err (sticky framing error)
// master = pixel producer / consumer (testbench or surrounding system)
// slave  = the filter itself
interface blur_filter_param_if #(
    parameter int DATA_W = 12
);
    logic              valid_in;
    logic              ready_in;
    logic              startofpacket_in;
    logic              endofpacket_in;
    logic [DATA_W-1:0] data_in;
    logic              blur_en;
    logic              valid_out;
    logic              ready_out;
    logic              startofpacket_out;
    logic              endofpacket_out;
    logic [DATA_W-1:0] data_out;
    logic              frame_err;

    modport master (
        output valid_in, startofpacket_in, endofpacket_in, data_in, blur_en, ready_out,
        input  ready_in, valid_out, startofpacket_out, endofpacket_out, data_out, frame_err
    );

    modport slave (
        input  valid_in, startofpacket_in, endofpacket_in, data_in, blur_en, ready_out,
        output ready_in, valid_out, startofpacket_out, endofpacket_out, data_out, frame_err
    );
endinterface

// File: rtl/blur_filter_param.sv
// 3x3 box blur on a streaming frame (trailing window ending at the current pixel).
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - blur_filter_param_if.slave: sink/source handshake, SOP/EOP, data,
//            blur_en (latched on SOP), frame_err
// Pipeline: capture (counters, window) -> channel sums -> divide/output register.
// A beat accepted at edge N is presented on valid_out after edge N+2.
module blur_filter_param #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    blur_filter_param_if.slave bus
);
    localparam int DATA_W = NUM_CH * CH_W;
    localparam int SUM_W  = CH_W + 4;
    localparam int COL_W  = (IMG_WIDTH  > 4) ? $clog2(IMG_WIDTH)  : 2;
    localparam int ROW_W  = (IMG_HEIGHT > 4) ? $clog2(IMG_HEIGHT) : 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // handshake
    logic adv, acc;
    logic [2:0] vld_pipe;   // [0] capture, [1] sums, [2] output

    assign adv           = !vld_pipe[2] || bus.ready_out;
    assign acc           = bus.valid_in && adv;
    assign bus.ready_in  = adv;
    assign bus.valid_out = vld_pipe[2];

    // position tracking
    logic [COL_W-1:0] col_q, col_c, col_nx;
    logic [ROW_W-1:0] row_q, row_c, row_nx;
    logic             mode_q, mode_c;
    logic             full_q, full_c, full_nx;   // last line of frame already completed
    logic             err_q, err_nx;
    logic             bypass_c;

    always_comb begin
        col_c  = col_q;
        row_c  = row_q;
        mode_c = mode_q;
        full_c = full_q;
        // an SOP beat is position (0,0) whatever the counters say
        if (bus.startofpacket_in) begin
            col_c  = '0;
            row_c  = '0;
            mode_c = bus.blur_en;
            full_c = 1'b0;
        end
        col_nx  = col_c + 1'b1;
        row_nx  = row_c;
        full_nx = full_c;
        if (col_c == COL_LAST) begin
            col_nx = '0;
            // row saturates; a further beat without SOP is an overrun
            if (row_c == ROW_LAST) full_nx = 1'b1;
            else                   row_nx  = row_c + 1'b1;
        end
        // SOP clears first, so SOP+EOP on one beat is judged at (0,0)
        err_nx = (bus.startofpacket_in ? 1'b0 : err_q)
               | full_c
               | (bus.endofpacket_in && !(col_c == COL_LAST && row_c == ROW_LAST));
        bypass_c = !mode_c || (row_c < ROW_W'(2)) || (col_c < COL_W'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= 1'b0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (acc) begin
            col_q  <= col_nx;
            row_q  <= row_nx;
            mode_q <= mode_c;
            full_q <= full_nx;
            err_q  <= err_nx;
        end
    end

    assign bus.frame_err = err_q;

    // line buffers: lb1 holds row r-1, lb2 row r-2 at each column
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col_c] <= bus.data_in;
            lb2[col_c] <= lb1[col_c];
        end
    end

    // window [row][col]: row 0 = r-2, 2 = r; col 2 = newest column
    logic [2:0][2:0][DATA_W-1:0] win_q;
    logic              byp0, sop0, eop0;
    logic [DATA_W-1:0] raw0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            byp0  <= 1'b1;
            sop0  <= 1'b0;
            eop0  <= 1'b0;
            raw0  <= '0;
        end else if (acc) begin
            for (int i = 0; i < 3; i++) win_q[i][1:0] <= win_q[i][2:1];
            win_q[0][2] <= lb2[col_c];
            win_q[1][2] <= lb1[col_c];
            win_q[2][2] <= bus.data_in;
            byp0 <= bypass_c;
            sop0 <= bus.startofpacket_in;
            eop0 <= bus.endofpacket_in;
            raw0 <= bus.data_in;
        end
    end

    // per-channel sums and divide-by-9
    logic [NUM_CH-1:0][SUM_W-1:0] sum_c, sum1;
    logic [DATA_W-1:0]            div_c;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        always_comb begin
            sum_c[ch] = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    sum_c[ch] = sum_c[ch] + SUM_W'(win_q[i][j][ch*CH_W +: CH_W]);
        end
        assign div_c[ch*CH_W +: CH_W] = CH_W'(sum1[ch] / SUM_W'(9));
    end

    logic              byp1, sop1, eop1;
    logic [DATA_W-1:0] raw1;
    logic              sop2, eop2;
    logic [DATA_W-1:0] data2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sum1     <= '0;
            byp1     <= 1'b1;
            sop1     <= 1'b0;
            eop1     <= 1'b0;
            raw1     <= '0;
            sop2     <= 1'b0;
            eop2     <= 1'b0;
            data2    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[1:0], acc};
            sum1     <= sum_c;
            byp1     <= byp0;
            sop1     <= sop0;
            eop1     <= eop0;
            raw1     <= raw0;
            sop2     <= sop1;
            eop2     <= eop1;
            data2    <= byp1 ? raw1 : div_c;
        end
    end

    assign bus.startofpacket_out = sop2;
    assign bus.endofpacket_out   = eop2;
    assign bus.data_out          = data2;
endmodule
